// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window generator and the downstream edge stage.
//   PIX_W          bits per grey pixel
//   WIN_W          bits in one packed 3x3 window word
//   WIN_TL..WIN_BR byte index of each window position, k = 3*row + col
//                  (row 0 = oldest/top line, col 0 = leftmost/oldest column)
package sobel_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_W = 9 * PIX_W;

    localparam int unsigned WIN_TL = 0;
    localparam int unsigned WIN_TC = 1;
    localparam int unsigned WIN_TR = 2;
    localparam int unsigned WIN_ML = 3;
    localparam int unsigned WIN_MC = 4;
    localparam int unsigned WIN_MR = 5;
    localparam int unsigned WIN_BL = 6;
    localparam int unsigned WIN_BC = 7;
    localparam int unsigned WIN_BR = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage for the Sobel window generator.
// Single port, asynchronous read, synchronous write; a read in the same cycle as a write to the
// same address returns the old contents. Storage is never cleared.
//   i_clk    clock, write on rising edge
//   i_we     write enable
//   i_addr   column address (read and write)
//   i_wdata  pixel to store at i_addr
//   o_rdata  current contents at i_addr
module sobel_line_buffer #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned PIX_W = sobel_pkg::PIX_W,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata
);

    import sobel_pkg::*;

    logic [PIX_W-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Sobel window generator: buffers the two previous rows of a raster pixel stream and emits the
// 3x3 neighbourhood of every pixel that completes one, packed into a single word.
//   i_clk               system clock
//   i_rst               synchronous active-high reset
//   i_pixel_data        input pixel, raster order
//   i_pixel_data_valid  input pixel qualifier (gaps allowed, no backpressure)
//   o_pixel_data        3x3 window, byte k = 3*row + col
//   o_pixel_data_valid  one-cycle window qualifier
//   o_line_done         pulse after the last pixel of a row is accepted
//   o_frame_done        pulse after the last pixel of a frame is accepted
module sobel_window_gen #(
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 512,
    parameter int unsigned PIX_W      = sobel_pkg::PIX_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PIX_W-1:0]   i_pixel_data,
    input  logic               i_pixel_data_valid,
    output logic [9*PIX_W-1:0] o_pixel_data,
    output logic               o_pixel_data_valid,
    output logic               o_line_done,
    output logic               o_frame_done
);

    import sobel_pkg::*;

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last;
    logic          row_last;

    logic [PIX_W-1:0] top_rd;
    logic [PIX_W-1:0] mid_rd;

    logic [PIX_W-1:0] win_q [9];
    logic             valid_q;
    logic             line_done_q;
    logic             frame_done_q;

    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_pixel_data_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Each accepted pixel pushes its column one line deeper: mid -> top, pixel -> mid.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W),
        .AW    (CW)
    ) u_lb_top (
        .i_clk   (i_clk),
        .i_we    (i_pixel_data_valid),
        .i_addr  (col_q),
        .i_wdata (mid_rd),
        .o_rdata (top_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W),
        .AW    (CW)
    ) u_lb_mid (
        .i_clk   (i_clk),
        .i_we    (i_pixel_data_valid),
        .i_addr  (col_q),
        .i_wdata (i_pixel_data),
        .o_rdata (mid_rd)
    );

    // Window shifts left; the new right column is {row r-2, row r-1, row r} at column c.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else if (i_pixel_data_valid) begin
            win_q[WIN_TL] <= win_q[WIN_TC];
            win_q[WIN_TC] <= win_q[WIN_TR];
            win_q[WIN_TR] <= top_rd;
            win_q[WIN_ML] <= win_q[WIN_MC];
            win_q[WIN_MC] <= win_q[WIN_MR];
            win_q[WIN_MR] <= mid_rd;
            win_q[WIN_BL] <= win_q[WIN_BC];
            win_q[WIN_BC] <= win_q[WIN_BR];
            win_q[WIN_BR] <= i_pixel_data;
        end
    end

    // c >= 2 keeps windows from mixing the tail of the previous row; r >= 2 keeps stale RAM out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q      <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            valid_q      <= i_pixel_data_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));
            line_done_q  <= i_pixel_data_valid && col_last;
            frame_done_q <= i_pixel_data_valid && col_last && row_last;
        end
    end

    always_comb begin
        o_pixel_data = '0;
        for (int k = 0; k < 9; k++) begin
            o_pixel_data[k*PIX_W +: PIX_W] = win_q[k];
        end
    end

    assign o_pixel_data_valid = valid_q;
    assign o_line_done        = line_done_q;
    assign o_frame_done       = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a 4x4 instance driven with pixel = 16*r + c (with and without gaps,
// back-to-back frames, mid-frame reset) and an 8x3 instance driven with random pixels. Expected
// windows are cut straight out of a stored copy of the frame.
module tb_sobel_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 4x4 instance
    logic        a_rst;
    logic [7:0]  a_pin;
    logic        a_vin;
    logic [71:0] a_pout;
    logic        a_vout;
    logic        a_ld;
    logic        a_fd;

    // 8x3 instance
    logic        b_rst;
    logic [7:0]  b_pin;
    logic        b_vin;
    logic [71:0] b_pout;
    logic        b_vout;
    logic        b_ld;
    logic        b_fd;

    sobel_window_gen #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4),
        .PIX_W      (8)
    ) u_dut_a (
        .i_clk              (clk),
        .i_rst              (a_rst),
        .i_pixel_data       (a_pin),
        .i_pixel_data_valid (a_vin),
        .o_pixel_data       (a_pout),
        .o_pixel_data_valid (a_vout),
        .o_line_done        (a_ld),
        .o_frame_done       (a_fd)
    );

    sobel_window_gen #(
        .IMG_WIDTH  (8),
        .IMG_HEIGHT (3),
        .PIX_W      (8)
    ) u_dut_b (
        .i_clk              (clk),
        .i_rst              (b_rst),
        .i_pixel_data       (b_pin),
        .i_pixel_data_valid (b_vin),
        .o_pixel_data       (b_pout),
        .o_pixel_data_valid (b_vout),
        .o_line_done        (b_ld),
        .o_frame_done       (b_fd)
    );

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model, 4x4 ----------------
    int          a_r, a_c;
    logic [7:0]  a_img [4][4];
    logic [71:0] a_hold;
    bit          a_hold_known;
    int          a_nwin, a_nld, a_nfd;
    logic [71:0] a_seen [$];

    function automatic logic [71:0] a_window(input int r, input int c);
        logic [71:0] w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = a_img[r-2+i][c-2+j];
        return w;
    endfunction

    task automatic step_a(input bit v, input logic [7:0] p);
        bit          ev, eld, efd;
        logic [71:0] ew;
        ev = 1'b0; eld = 1'b0; efd = 1'b0;
        ew = a_hold;
        a_vin = v;
        a_pin = p;
        if (v) begin
            a_img[a_r][a_c] = p;
            ev  = (a_r >= 2) && (a_c >= 2);
            eld = (a_c == 3);
            efd = eld && (a_r == 3);
            if (ev) ew = a_window(a_r, a_c);
            if (a_c == 3) begin
                a_c = 0;
                a_r = (a_r == 3) ? 0 : a_r + 1;
            end else begin
                a_c++;
            end
        end
        @(posedge clk);
        #1;
        check_eq("a_valid", 72'(a_vout), 72'(ev));
        check_eq("a_line_done", 72'(a_ld), 72'(eld));
        check_eq("a_frame_done", 72'(a_fd), 72'(efd));
        if (ev || (!v && a_hold_known)) check_eq("a_window", a_pout, ew);
        if (ev) begin
            a_hold = ew;
            a_hold_known = 1'b1;
        end else if (v) begin
            a_hold_known = 1'b0;
        end
        if (a_vout) begin
            a_nwin++;
            a_seen.push_back(a_pout);
        end
        if (a_ld) a_nld++;
        if (a_fd) a_nfd++;
        @(negedge clk);
        a_vin = 1'b0;
    endtask

    task automatic reset_a(input int n);
        a_rst = 1'b1;
        a_vin = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("a_rst_valid", 72'(a_vout), 72'd0);
            check_eq("a_rst_done", 72'({a_ld, a_fd}), 72'd0);
            check_eq("a_rst_window", a_pout, 72'd0);
        end
        @(negedge clk);
        a_rst = 1'b0;
        a_r = 0;
        a_c = 0;
        a_hold = '0;
        a_hold_known = 1'b1;
    endtask

    // mode 0: continuous, 1: one gap after every pixel, 2: random gaps
    task automatic frame_a(input int mode, input int npix);
        for (int k = 0; k < npix; k++) begin
            step_a(1'b1, 8'(16 * (k / 4) + (k % 4)));
            if (mode == 1) step_a(1'b0, 8'($urandom));
            if (mode == 2) repeat ($urandom_range(0, 2)) step_a(1'b0, 8'($urandom));
        end
    endtask

    task automatic clear_a();
        a_nwin = 0;
        a_nld  = 0;
        a_nfd  = 0;
        a_seen.delete();
    endtask

    task automatic pad_seen_a();
        while (a_seen.size() < 4) a_seen.push_back('x);
    endtask

    // ---------------- reference model, 8x3 ----------------
    int          b_r, b_c;
    logic [7:0]  b_img [3][8];
    int          b_nwin;

    function automatic logic [71:0] b_window(input int r, input int c);
        logic [71:0] w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = b_img[r-2+i][c-2+j];
        return w;
    endfunction

    task automatic step_b(input bit v, input logic [7:0] p);
        bit          ev;
        logic [71:0] ew;
        ev = 1'b0;
        ew = '0;
        b_vin = v;
        b_pin = p;
        if (v) begin
            b_img[b_r][b_c] = p;
            ev = (b_r >= 2) && (b_c >= 2);
            if (ev) ew = b_window(b_r, b_c);
            if (b_c == 7) begin
                b_c = 0;
                b_r = (b_r == 2) ? 0 : b_r + 1;
            end else begin
                b_c++;
            end
        end
        @(posedge clk);
        #1;
        check_eq("b_valid", 72'(b_vout), 72'(ev));
        if (ev) check_eq("b_window", b_pout, ew);
        if (b_vout) b_nwin++;
        @(negedge clk);
        b_vin = 1'b0;
    endtask

    localparam logic [71:0] WinFirst = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] WinRow3  = 72'h32_31_30_22_21_20_12_11_10;
    localparam logic [71:0] WinLast  = 72'h33_32_31_23_22_21_13_12_11;

    initial begin
        a_rst = 1'b1; a_vin = 1'b0; a_pin = '0;
        b_rst = 1'b1; b_vin = 1'b0; b_pin = '0;
        a_r = 0; a_c = 0; b_r = 0; b_c = 0;
        a_hold = '0; a_hold_known = 1'b1;
        clear_a();

        repeat (2) @(posedge clk);
        #1;
        check_eq("b_rst_valid", 72'(b_vout), 72'd0);
        check_eq("b_rst_window", b_pout, 72'd0);
        check_eq("b_rst_done", 72'({b_ld, b_fd}), 72'd0);
        @(negedge clk);
        b_rst = 1'b0;
        reset_a(2);

        // continuous frame
        clear_a();
        frame_a(0, 16);
        check_eq("t1_count", 72'(a_nwin), 72'd4);
        pad_seen_a();
        check_eq("t1_first", a_seen[0], WinFirst);
        check_eq("t1_row3", a_seen[2], WinRow3);
        check_eq("t1_last", a_seen[3], WinLast);

        // valid toggled 1-0-1-0
        clear_a();
        frame_a(1, 16);
        check_eq("t2_count", 72'(a_nwin), 72'd4);
        pad_seen_a();
        check_eq("t2_first", a_seen[0], WinFirst);
        check_eq("t2_last", a_seen[3], WinLast);

        // two back-to-back frames, first one with random gaps
        clear_a();
        frame_a(2, 16);
        frame_a(0, 16);
        check_eq("t3_count", 72'(a_nwin), 72'd8);
        check_eq("t3_line_done", 72'(a_nld), 72'd8);
        check_eq("t3_frame_done", 72'(a_nfd), 72'd2);

        // reset after pixel (2,1), then a full frame
        frame_a(0, 10);
        reset_a(2);
        clear_a();
        frame_a(0, 16);
        check_eq("t4_count", 72'(a_nwin), 72'd4);
        pad_seen_a();
        check_eq("t4_first", a_seen[0], WinFirst);
        check_eq("t4_last", a_seen[3], WinLast);

        // 8x3 random frames, with occasional gaps in the second
        for (int f = 0; f < 2; f++) begin
            b_nwin = 0;
            for (int k = 0; k < 24; k++) begin
                step_b(1'b1, 8'($urandom));
                if (f == 1 && $urandom_range(0, 3) == 0) step_b(1'b0, 8'($urandom));
            end
            check_eq("t6_count", 72'(b_nwin), 72'd6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
